// File: rtl/comet_mem_pkg.sv
// Shared types and constants for the COMET II test-RAM arbiter.
package comet_mem_pkg;

   localparam int DATA_W    = 16;
   localparam int RAM_WORDS = 256;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/comet_mem_prio_sel.sv
// Winner select: CPU has fixed priority unless the loader has waited MAX_WAIT grants.
module comet_mem_prio_sel
   import comet_mem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic [3:0] wait_cnt_i,
   output logic       valid_o,
   output logic       winner_o
);

   always_comb begin
      valid_o  = req0_i | req1_i;
      winner_o = PORT_CPU;
      if (req1_i && (!req0_i || (wait_cnt_i == 4'(MAX_WAIT)))) begin
         winner_o = PORT_LDR;
      end
   end

endmodule

// File: rtl/comet_mem_arbiter.sv
// Two-port arbiter sharing the single-port test RAM between the CPU (port 0)
// and the loader/debug port (port 1); one IDLE/ACCESS/DONE pass per access.
module comet_mem_arbiter
   import comet_mem_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int MAX_WAIT  = 4
) (
   input  logic              mclk_i,
   input  logic              rst_n_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [DATA_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              err0_o,
   output logic              err1_o,
   output logic              ram_we_o,
   output logic [DATA_W-1:0] ram_waddr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic              ram_re_o,
   output logic [DATA_W-1:0] ram_raddr_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              busy_o,
   output logic              gnt_id_o
);

   state_e            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic [3:0]        waitCnt_q, waitCnt_d;
   logic              rangeErr_q, rangeErr_d;

   logic              selValid;
   logic              selWinner;
   logic              rangeErr;
   logic              inAccess;
   logic              inDone;

   comet_mem_prio_sel #(
      .MAX_WAIT (MAX_WAIT)
   ) u_prio_sel (
      .req0_i     (req0_i),
      .req1_i     (req1_i),
      .wait_cnt_i (waitCnt_q),
      .valid_o    (selValid),
      .winner_o   (selWinner)
   );

   assign rangeErr = (addr_q >> ADDR_BITS) != '0;
   assign inAccess = (state_q == ACCESS);
   assign inDone   = (state_q == DONE);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      waitCnt_d  = waitCnt_q;
      rangeErr_d = rangeErr_q;

      case (state_q)
         IDLE: begin
            if (!req1_i) begin
               waitCnt_d = '0;
            end
            if (selValid) begin
               gnt_d   = selWinner;
               we_d    = (selWinner == PORT_LDR) ? we1_i    : we0_i;
               addr_d  = (selWinner == PORT_LDR) ? addr1_i  : addr0_i;
               wdata_d = (selWinner == PORT_LDR) ? wdata1_i : wdata0_i;
               state_d = ACCESS;
               if (selWinner == PORT_LDR) begin
                  waitCnt_d = '0;
               end else if (req1_i && (waitCnt_q != 4'(MAX_WAIT))) begin
                  waitCnt_d = waitCnt_q + 4'd1;
               end
            end
         end
         ACCESS: begin
            // Out-of-range reads return zero; writes leave the read registers alone.
            rangeErr_d = rangeErr;
            if (!we_q) begin
               if (gnt_q == PORT_LDR) begin
                  rdata1_d = rangeErr ? '0 : ram_rdata_i;
               end else begin
                  rdata0_d = rangeErr ? '0 : ram_rdata_i;
               end
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge mclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         gnt_q      <= PORT_CPU;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         waitCnt_q  <= '0;
         rangeErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         waitCnt_q  <= waitCnt_d;
         rangeErr_q <= rangeErr_d;
      end
   end

   // RAM strobes decode from the async-reset state register, so reset kills them at once.
   assign ram_we_o    = inAccess & we_q & ~rangeErr;
   assign ram_re_o    = inAccess & ~we_q & ~rangeErr;
   assign ram_waddr_o = addr_q;
   assign ram_raddr_o = addr_q;
   assign ram_wdata_o = wdata_q;

   assign ack0_o   = inDone & (gnt_q == PORT_CPU);
   assign ack1_o   = inDone & (gnt_q == PORT_LDR);
   assign err0_o   = ack0_o & rangeErr_q;
   assign err1_o   = ack1_o & rangeErr_q;
   assign rdata0_o = rdata0_q;
   assign rdata1_o = rdata1_q;
   assign busy_o   = (state_q != IDLE);
   assign gnt_id_o = gnt_q;

endmodule

// File: tb/tb_comet_mem_arbiter.sv
// Self-checking bench for comet_mem_arbiter with a behavioural 256x16 test RAM.
module tb_comet_mem_arbiter;
   import comet_mem_pkg::*;

   typedef struct {
      logic        port;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] expRdata;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic        port;
      logic        we;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   logic        mclk = 1'b0;
   logic        rstN;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [15:0] rdata0, rdata1;
   logic        ramWe, ramRe, busy, gntId;
   logic [15:0] ramWaddr, ramWdata, ramRaddr, ramRdata;

   logic [15:0] mem [RAM_WORDS];
   logic        memLoaded = 1'b0;
   int          cycle = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sbQ[$];
   int          ackCycles[$];
   logic [15:0] lastRdata [2];
   logic        weSeen;
   vec_t        vecs [12];

   comet_mem_arbiter #(
      .ADDR_BITS (8),
      .MAX_WAIT  (4)
   ) dut (
      .mclk_i      (mclk),
      .rst_n_i     (rstN),
      .req0_i      (req0),
      .req1_i      (req1),
      .we0_i       (we0),
      .we1_i       (we1),
      .addr0_i     (addr0),
      .addr1_i     (addr1),
      .wdata0_i    (wdata0),
      .wdata1_i    (wdata1),
      .ack0_o      (ack0),
      .ack1_o      (ack1),
      .rdata0_o    (rdata0),
      .rdata1_o    (rdata1),
      .err0_o      (err0),
      .err1_o      (err1),
      .ram_we_o    (ramWe),
      .ram_waddr_o (ramWaddr),
      .ram_wdata_o (ramWdata),
      .ram_re_o    (ramRe),
      .ram_raddr_o (ramRaddr),
      .ram_rdata_i (ramRdata),
      .busy_o      (busy),
      .gnt_id_o    (gntId)
   );

   always #5 mclk = ~mclk;

   always @(posedge mclk) cycle <= cycle + 1;

   // Test RAM: preloaded once, written on negedge, read combinationally.
   always @(negedge mclk) begin
      if (!memLoaded) begin
         for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 16'h0000;
         mem[8'h00] <= 16'h1270;
         mem[8'h01] <= 16'h0070;
         mem[8'h25] <= 16'h0029;
         mem[8'h50] <= 16'h5050;
         memLoaded  <= 1'b1;
      end else if (ramWe) begin
         mem[ramWaddr[7:0]] <= ramWdata;
      end
   end

   assign ramRdata = ramRe ? mem[ramRaddr[7:0]] : 16'hDEAD;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
   endtask

   task automatic pushExp(input logic port, input logic we, input logic [15:0] rdata, input logic err);
      exp_t e;
      e.port = port; e.we = we; e.rdata = rdata; e.err = err;
      sbQ.push_back(e);
   endtask

   task automatic waitAcks(input int n, input bit dropOnAck, input int budget, output int cycUsed);
      int   got;
      exp_t e;
      got     = 0;
      cycUsed = 0;
      while (got < n && cycUsed < budget) begin
         @(negedge mclk);
         cycUsed++;
         if (ramWe) weSeen = 1'b1;
         if (ack0 || ack1) begin
            if (sbQ.size() == 0) begin
               checkOutput("sb_unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
               e = sbQ.pop_front();
               if (!e.we) lastRdata[e.port] = e.rdata;
               checkOutput("ack_vector", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
               checkOutput("gnt_id", {31'd0, gntId}, {31'd0, e.port});
               checkOutput("err", {31'd0, e.port ? err1 : err0}, {31'd0, e.err});
               checkOutput("rdata0", {16'd0, rdata0}, {16'd0, lastRdata[0]});
               checkOutput("rdata1", {16'd0, rdata1}, {16'd0, lastRdata[1]});
               if (dropOnAck) begin
                  if (e.port) req1 = 1'b0; else req0 = 1'b0;
               end
            end
            ackCycles.push_back(cycle);
            got++;
         end
      end
      checkOutput("ack_count", got, n);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   cyc;
      logic ackSeen;

      rstN = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      lastRdata[0] = '0; lastRdata[1] = '0;
      weSeen = 1'b0;

      vecs[0]  = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1270, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 16'h0025, 16'h0000, 16'h0029, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0070, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 16'h0200, 16'h7777, 16'h0000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1270, 1'b0};

      repeat (3) @(posedge mclk);
      #1;
      checkOutput("rst_ack_err", {28'd0, ack0, ack1, err0, err1}, 32'd0);
      checkOutput("rst_ram_en", {30'd0, ramWe, ramRe}, 32'd0);
      checkOutput("rst_rdata", {rdata0, rdata1}, 32'd0);
      checkOutput("rst_ram_addr", {ramWaddr, ramRaddr}, 32'd0);
      checkOutput("rst_ram_wdata", {16'd0, ramWdata}, 32'd0);
      checkOutput("rst_busy_gnt", {30'd0, busy, gntId}, 32'd0);
      rstN = 1'b1;

      $display("[TB] single-port vector table");
      for (int i = 0; i < 12; i++) begin
         @(posedge mclk);
         #1;
         applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         pushExp(vecs[i].port, vecs[i].we, vecs[i].expRdata, vecs[i].expErr);
         weSeen = 1'b0;
         waitAcks(1, 1'b1, 10, cyc);
         checkOutput($sformatf("latency_v%0d", i), cyc, 3);
         checkOutput($sformatf("ram_we_v%0d", i), {31'd0, weSeen},
                     {31'd0, vecs[i].we & ~vecs[i].expErr});
      end

      $display("[TB] simultaneous requests");
      @(posedge mclk);
      #1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
      pushExp(1'b0, 1'b0, 16'h1270, 1'b0);
      pushExp(1'b1, 1'b0, 16'h0070, 1'b0);
      ackCycles.delete();
      waitAcks(2, 1'b1, 20, cyc);
      if (ackCycles.size() == 2) checkOutput("simul_spacing", ackCycles[1] - ackCycles[0], 3);

      $display("[TB] continuous contention");
      @(posedge mclk);
      #1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) pushExp(1'b1, 1'b0, 16'h0070, 1'b0);
         else                  pushExp(1'b0, 1'b0, 16'h1270, 1'b0);
      end
      ackCycles.delete();
      waitAcks(10, 1'b0, 40, cyc);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int k = 1; k < ackCycles.size(); k++) begin
         checkOutput($sformatf("contention_spacing_%0d", k), ackCycles[k] - ackCycles[k-1], 3);
      end

      $display("[TB] reset during ACCESS");
      @(posedge mclk);
      #1;
      applyStimulus(1'b1, 1'b1, 16'h0050, 16'hAAAA);
      @(posedge mclk);
      #1;
      checkOutput("mid_access_we", {31'd0, ramWe}, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("reset_we_async", {31'd0, ramWe}, 32'd0);
      req1 = 1'b0;
      ackSeen = 1'b0;
      repeat (4) begin
         @(negedge mclk);
         ackSeen = ackSeen | ack0 | ack1;
      end
      @(posedge mclk);
      #1;
      rstN = 1'b1;
      lastRdata[0] = '0;
      lastRdata[1] = '0;
      checkOutput("reset_no_ack", {31'd0, ackSeen}, 32'd0);
      checkOutput("reset_mem_kept", {16'd0, mem[8'h50]}, 32'h5050);
      @(negedge mclk);
      checkOutput("reset_idle", {31'd0, busy}, 32'd0);
      checkOutput("reset_rdata", {rdata0, rdata1}, 32'd0);
      @(posedge mclk);
      #1;
      applyStimulus(1'b0, 1'b0, 16'h0050, 16'h0000);
      pushExp(1'b0, 1'b0, 16'h5050, 1'b0);
      waitAcks(1, 1'b1, 10, cyc);
      checkOutput("post_reset_latency", cyc, 3);

      checkOutput("sb_drained", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
